sram_frame_writer: RTL and testbench
====================================

Name: sram_frame_writer

Overview:
- Upstream stage of the pixel-buffer system. Accepts a pixel stream and writes one full frame into external SRAM through the system's SRAM conduit (write / chipselect / outputenable / address / data_io / byteenable).
- The pixel buffer's VGA DMA then scans that frame out.
- Supports two frame buffers: front or back, selected per frame.
- Absorbs source bursts in a small input FIFO and paces SRAM writes at a fixed strobe width.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, pixel/SRAM word width.
- WR_CYCLES, 2, cycles write+chipselect held per word (>=1).
- FIFO_DEPTH, 8, input FIFO entries (power of 2, >=2).
- BUF1_BASE, 20'h20000, word base of buffer 1. Buffer 0 base is 0.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse: arm capture of one frame.
- buf_sel  in  1  target buffer; sampled on accepted start.
- px_data  in  DATA_W  pixel (RGB565).
- px_sop  in  1  marks first pixel of a frame.
- px_valid  in  1  source has pixel.
- px_ready  out  1  block accepts pixel this cycle.
- busy  out  1  frame capture in progress.
- frame_done  out  1  1-cycle pulse after last word written.
- sync_err  out  1  1-cycle pulse on unexpected sop mid-frame.
- sram_write  out  1  conduit write strobe.
- sram_chipselect  out  1  conduit chipselect.
- sram_outputenable  out  1  conduit output enable; constant 0.
- sram_address  out  ADDR_W  conduit word address.
- sram_data_io  inout  DATA_W  driven only in WRITE, else high-Z.
- sram_byteenable  out  2  2'b11 during WRITE, else 2'b00.

Behaviour:
- Clock and reset: one clock (clk_clk); reset_reset is asynchronous and active-high.
- Reset state: state=IDLE, FIFO empty, px_ready=0, busy=0, frame_done=0, sync_err=0, write=0, chipselect=0, outputenable=0, address=0, byteenable=0, data_io=Z.
- Handshake: a pixel transfers when px_valid & px_ready.
  - px_ready = (state!=IDLE && state!=DONE) && !fifo_full.
  - FIFO stores {sop, data}.
  - Write-to-read latency is 1 cycle (registered).
- States:
  - IDLE: start → latch base = buf_sel ? BUF1_BASE : 0; go to WAIT_SOP; busy=1. Start in any other state is ignored.
  - WAIT_SOP: pop entries. Entries with sop=0 are discarded. An entry with sop=1 sets ptr=base, cnt=0 and goes to WRITE.
  - WRITE: address=ptr, data_io=pixel, chipselect=1, write=1, byteenable=11, held exactly WR_CYCLES cycles.
  - RECOVER: 1 cycle with write=0, chipselect=0, data_io=Z. Then:
    - if cnt == H_RES*V_RES-1 → DONE;
    - else ptr++, cnt++ → FETCH.
  - FETCH: wait for FIFO non-empty, then pop.
    - If the popped sop=1: pulse sync_err, ptr=base, cnt=0, write that pixel (frame restarts).
    - Either way, go to WRITE.
  - DONE: frame_done=1 for one cycle, busy=0 → IDLE. FIFO is flushed on entering IDLE.
- Throughput: one word per WR_CYCLES+1 cycles when the FIFO is non-empty. A stalled FIFO holds in FETCH with all strobes low.
- Width rules:
  - cnt is wide enough for H_RES*V_RES-1.
  - ptr is ADDR_W; base+cnt wrap modulo 2^ADDR_W is allowed and not flagged.
- Boundary conditions:
  - FIFO full → px_ready=0.
  - Simultaneous push and pop when full is allowed; occupancy stays the same.
  - Simultaneous push and pop when empty is not possible; the read is registered.
  - reset_reset mid-WRITE: strobes drop asynchronously and the frame is abandoned.
  - px_sop on the final pixel of a frame is treated as a resync, not a completion.

Decomposition:
- Shared package sram_px_pkg:
  - state enum (IDLE, WAIT_SOP, FETCH, WRITE, RECOVER, DONE);
  - FRAME_WORDS = H_RES*V_RES;
  - RGB565 pixel typedef.
- Sub-module px_fifo: synchronous FIFO of width DATA_W+1 and depth FIFO_DEPTH. Provides push, pop, full, empty and registered dout; flush clears it.

Test Plan:
- Reset then idle: reset_reset=1 for 3 cycles → all strobes 0, data_io=Z, px_ready=0, busy=0.
- Basic frame, H_RES=4, V_RES=2, WR_CYCLES=2, buf_sel=0, sequence 0x1000..0x1007 with sop on the first pixel → writes to addresses 0..7 with matching data. Each write is high for exactly 2 cycles followed by a 1-cycle gap. frame_done pulses once, then busy=0.
- Buffer 1 with pre-sop junk: buf_sel=1, three pixels without sop, then sop 0xABCD → junk is discarded; first write is address 0x20000 with data 0xABCD.
- Backpressure: hold px_valid=1 continuously → px_ready drops after 8 unread entries; no pixel is lost or duplicated (compare against a scoreboard).
- Mid-frame resync: sop on pixel 5 of 8 → sync_err pulses once; that pixel is written to base+0, and the frame completes after 8 more words.
- Async reset during WRITE → write/chipselect drop the same cycle. After reset, start yields a clean frame starting at base.

Source files
------------

// File: rtl/sram_px_pkg.sv
// Shared types and constants for the SRAM frame writer: FSM states,
// default frame geometry and the RGB565 pixel layout.
package sram_px_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_SOP = 3'd1,
      FETCH    = 3'd2,
      WRITE    = 3'd3,
      RECOVER  = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam int unsigned H_RES_DEF   = 320;
   localparam int unsigned V_RES_DEF   = 240;
   localparam int unsigned FRAME_WORDS = H_RES_DEF * V_RES_DEF;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
      return h * v;
   endfunction

endpackage

// File: rtl/px_fifo.sv
// Small synchronous first-word-fall-through FIFO. Storage is registered, so a
// pushed entry appears on dout one cycle after the push; flush empties it.
module px_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          wr_en;
   logic          rd_en;

   // A push while full is only taken when a pop frees a slot in the same cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sram_frame_writer.sv
// Captures one frame from a pixel stream and writes it word by word into SRAM
// through the conduit, into the front or back buffer chosen at start.
module sram_frame_writer
   import sram_px_pkg::*;
#(
   parameter int               H_RES      = 320,
   parameter int               V_RES      = 240,
   parameter int               ADDR_W     = 20,
   parameter int               DATA_W     = 16,
   parameter int               WR_CYCLES  = 2,
   parameter int               FIFO_DEPTH = 8,
   parameter logic [ADDR_W-1:0] BUF1_BASE = 20'h20000
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              start,
   input  logic              buf_sel,
   input  logic [DATA_W-1:0] px_data,
   input  logic              px_sop,
   input  logic              px_valid,
   output logic              px_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              sync_err,
   output logic              sram_write,
   output logic              sram_chipselect,
   output logic              sram_outputenable,
   output logic [ADDR_W-1:0] sram_address,
   inout  wire  [DATA_W-1:0] sram_data_io,
   output logic [1:0]        sram_byteenable
);

   localparam int unsigned FW   = frame_words(H_RES, V_RES);
   localparam int          CNT_W = $clog2(FW + 1);
   localparam int          WC_W  = $clog2(WR_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FW - 1);
   localparam logic [WC_W-1:0]  LAST_WC  = WC_W'(WR_CYCLES - 1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base, base_nxt;
   logic [ADDR_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [DATA_W-1:0]   pix, pix_nxt;
   logic [WC_W-1:0]     wr_cnt, wr_cnt_nxt;
   logic                sync_q, sync_nxt;

   logic                push, pop, flush, take;
   logic                fifo_full, fifo_empty;
   logic [DATA_W:0]     fifo_dout;
   logic                fifo_sop;
   logic [DATA_W-1:0]   fifo_px;
   logic                in_frame;

   assign fifo_sop = fifo_dout[DATA_W];
   assign fifo_px  = fifo_dout[DATA_W-1:0];

   px_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   ({px_sop, px_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state  <= IDLE;
         base   <= '0;
         ptr    <= '0;
         cnt    <= '0;
         pix    <= '0;
         wr_cnt <= '0;
         sync_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         base   <= base_nxt;
         ptr    <= ptr_nxt;
         cnt    <= cnt_nxt;
         pix    <= pix_nxt;
         wr_cnt <= wr_cnt_nxt;
         sync_q <= sync_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      base_nxt   = base;
      ptr_nxt    = ptr;
      cnt_nxt    = cnt;
      pix_nxt    = pix;
      wr_cnt_nxt = '0;
      sync_nxt   = 1'b0;
      pop        = 1'b0;
      flush      = 1'b0;
      take       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               base_nxt  = buf_sel ? BUF1_BASE : '0;
               state_nxt = WAIT_SOP;
            end
         end
         WAIT_SOP: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (fifo_sop) begin
                  ptr_nxt   = base;
                  cnt_nxt   = '0;
                  pix_nxt   = fifo_px;
                  state_nxt = WRITE;
               end
            end
         end
         WRITE: begin
            if (wr_cnt == LAST_WC) state_nxt  = RECOVER;
            else                   wr_cnt_nxt = wr_cnt + WC_W'(1);
         end
         RECOVER: begin
            if (cnt == LAST_CNT) begin
               state_nxt = DONE;
            end else begin
               ptr_nxt = ptr + ADDR_W'(1);
               cnt_nxt = cnt + CNT_W'(1);
               // Fetching here keeps back-to-back writes one gap cycle apart;
               // FETCH is only visited when the FIFO has run dry.
               if (!fifo_empty) take      = 1'b1;
               else             state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (!fifo_empty) take = 1'b1;
         end
         DONE: begin
            flush     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // A sop arriving mid-frame restarts the frame with that pixel at base.
      if (take) begin
         pop       = 1'b1;
         pix_nxt   = fifo_px;
         state_nxt = WRITE;
         if (fifo_sop) begin
            sync_nxt = 1'b1;
            ptr_nxt  = base;
            cnt_nxt  = '0;
         end
      end
   end

   // Pixel handshake: a word transfers on any cycle where px_valid and px_ready are both high.
   assign in_frame = (state != IDLE) && (state != DONE);
   assign px_ready = in_frame && !fifo_full;
   assign push     = px_valid && px_ready;
   assign busy     = in_frame;
   assign frame_done = (state == DONE);
   assign sync_err   = sync_q;

   assign sram_write        = (state == WRITE);
   assign sram_chipselect   = (state == WRITE);
   assign sram_outputenable = 1'b0;
   assign sram_address      = ptr;
   assign sram_byteenable   = (state == WRITE) ? 2'b11 : 2'b00;
   assign sram_data_io      = (state == WRITE) ? pix : 'z;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Bench for sram_frame_writer on a 4x2 frame: random pixel streams are checked
// against a frame-level model of which pixel lands at which SRAM word.
module tb_sram_frame_writer;

   localparam int H_RES      = 4;
   localparam int V_RES      = 2;
   localparam int FRAME      = H_RES * V_RES;
   localparam int WR_CYCLES  = 2;
   localparam int FIFO_DEPTH = 8;
   localparam int ADDR_W     = 20;
   localparam int DATA_W     = 16;
   localparam logic [ADDR_W-1:0] BUF1_BASE = 20'h20000;

   logic              clk_clk     = 1'b0;
   logic              reset_reset = 1'b1;
   logic              start       = 1'b0;
   logic              buf_sel     = 1'b0;
   logic [DATA_W-1:0] px_data     = '0;
   logic              px_sop      = 1'b0;
   logic              px_valid    = 1'b0;
   logic              px_ready, busy, frame_done, sync_err;
   logic              sram_write, sram_chipselect, sram_outputenable;
   logic [ADDR_W-1:0] sram_address;
   wire  [DATA_W-1:0] sram_data_io;
   logic [1:0]        sram_byteenable;

   sram_frame_writer #(
      .H_RES      (H_RES),
      .V_RES      (V_RES),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .WR_CYCLES  (WR_CYCLES),
      .FIFO_DEPTH (FIFO_DEPTH),
      .BUF1_BASE  (BUF1_BASE)
   ) dut (
      .clk_clk           (clk_clk),
      .reset_reset       (reset_reset),
      .start             (start),
      .buf_sel           (buf_sel),
      .px_data           (px_data),
      .px_sop            (px_sop),
      .px_valid          (px_valid),
      .px_ready          (px_ready),
      .busy              (busy),
      .frame_done        (frame_done),
      .sync_err          (sync_err),
      .sram_write        (sram_write),
      .sram_chipselect   (sram_chipselect),
      .sram_outputenable (sram_outputenable),
      .sram_address      (sram_address),
      .sram_data_io      (sram_data_io),
      .sram_byteenable   (sram_byteenable)
   );

   // ---------------- clock ----------------
   always #5 clk_clk = ~clk_clk;

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W:0]        stim_q[$];
   logic [DATA_W:0]        acc_q[$];
   logic [ADDR_W+DATA_W-1:0] wr_log[$];
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   int done_cnt  = 0;
   int sync_cnt  = 0;
   int wr_len    = 0;
   int gap       = 0;
   int wr_starts = 0;
   int acc_cnt   = 0;
   bit gap_chk   = 1'b0;
   bit first_wr  = 1'b0;
   bit occ_chk   = 1'b0;
   bit saw_full  = 1'b0;
   bit gappy     = 1'b0;

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- conduit monitor ----------------
   always @(negedge clk_clk) begin
      if (reset_reset) begin
         wr_len = 0;
         gap    = 0;
      end else begin
         if (frame_done) done_cnt++;
         if (sync_err)   sync_cnt++;
         check("outputenable", 36'(sram_outputenable), 36'(0));
         if (sram_write) begin
            if (wr_len == 0) begin
               if (gap_chk && !first_wr) check("write_gap", 36'(gap), 36'(1));
               first_wr = 1'b0;
               wr_starts++;
               wr_log.push_back({sram_address, sram_data_io});
            end else begin
               check("write_stable", {sram_address, sram_data_io}, wr_log[$]);
            end
            check("cs_with_write", 36'(sram_chipselect), 36'(1));
            check("be_with_write", 36'(sram_byteenable), 36'(2'b11));
            wr_len++;
            gap = 0;
         end else begin
            if (wr_len != 0) check("write_width", 36'(wr_len), 36'(WR_CYCLES));
            wr_len = 0;
            gap++;
            check("cs_idle", 36'(sram_chipselect), 36'(0));
            check("be_idle", 36'(sram_byteenable), 36'(0));
         end
         // Unread entries = pixels accepted minus words whose write has begun.
         if (occ_chk && wr_starts < FRAME) begin
            check("ready_vs_occupancy", 36'(px_ready), 36'((acc_cnt - wr_starts) < FIFO_DEPTH));
            if (!px_ready) saw_full = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic make_stream(input int n, input int sop_a, input int sop_b);
      stim_q.delete();
      for (int i = 0; i < n; i++)
         stim_q.push_back({(i == sop_a || i == sop_b) ? 1'b1 : 1'b0, 16'($urandom)});
   endtask

   task automatic drive_stream();
      int idx    = 0;
      int budget = 0;
      acc_q.delete();
      while (idx < stim_q.size() && budget < 400) begin
         if (gappy && $urandom_range(0, 3) == 0) begin
            px_valid = 1'b0;
         end else begin
            px_valid = 1'b1;
            {px_sop, px_data} = stim_q[idx];
         end
         #1;
         if (px_valid && px_ready) begin
            acc_q.push_back(stim_q[idx]);
            acc_cnt++;
            idx++;
         end
         @(negedge clk_clk);
         budget++;
      end
      px_valid = 1'b0;
      px_sop   = 1'b0;
      check("stream_accepted", 36'(idx), 36'(stim_q.size()));
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk_clk);
         n++;
      end
      #1;
      check("frame_done_seen", 36'(done_cnt != d0), 36'(1));
      check("busy_after_done", 36'(busy), 36'(0));
      check("ready_after_done", 36'(px_ready), 36'(0));
      repeat (6) @(negedge clk_clk);
      check("frame_done_once", 36'(done_cnt - d0), 36'(1));
   endtask

   // Frame-level reference: skip to the first sop, then place each pixel at
   // base + its index in the frame; a later sop restarts the index at 0.
   function automatic int build_model(input logic [ADDR_W-1:0] base);
      int  idx     = 0;
      int  syncs   = 0;
      bit  started = 1'b0;
      bit  fin     = 1'b0;
      logic [DATA_W:0] e;
      exp_q.delete();
      foreach (acc_q[i]) begin
         if (fin) break;
         e = acc_q[i];
         if (!started) begin
            if (!e[DATA_W]) continue;
            started = 1'b1;
            idx     = 0;
         end else if (e[DATA_W]) begin
            syncs++;
            idx = 0;
         end
         exp_q.push_back({base + ADDR_W'(idx), e[DATA_W-1:0]});
         if (idx == FRAME - 1) fin = 1'b1;
         else                  idx++;
      end
      return syncs;
   endfunction

   task automatic run_frame(input string name, input bit bsel, input bit poke, input bit gaps, input bit occ);
      int s0 = sync_cnt;
      int exp_sync;
      int n;
      wr_log.delete();
      wr_starts = 0;
      acc_cnt   = 0;
      first_wr  = 1'b1;
      saw_full  = 1'b0;
      gap_chk   = gaps;
      @(negedge clk_clk);
      start   = 1'b1;
      buf_sel = bsel;
      @(negedge clk_clk);
      start   = 1'b0;
      buf_sel = 1'($urandom_range(0, 1));
      occ_chk = occ;
      check({name, "_busy"}, 36'(busy), 36'(1));
      fork
         drive_stream();
         wait_done(600);
         begin
            if (poke) begin
               repeat (6) @(negedge clk_clk);
               start   = 1'b1;
               buf_sel = !bsel;
               @(negedge clk_clk);
               start   = 1'b0;
            end
         end
      join
      occ_chk = 1'b0;
      gap_chk = 1'b0;
      exp_sync = build_model(bsel ? BUF1_BASE : '0);
      check({name, "_sync_pulses"}, 36'(sync_cnt - s0), 36'(exp_sync));
      check({name, "_n_writes"}, 36'(wr_log.size()), 36'(exp_q.size()));
      n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_wr%0d", name, i), wr_log[i], exp_q[i]);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;

      // reset held for 3 cycles, then idle
      repeat (3) @(negedge clk_clk);
      check("rst_write", 36'(sram_write), 36'(0));
      check("rst_cs", 36'(sram_chipselect), 36'(0));
      check("rst_oe", 36'(sram_outputenable), 36'(0));
      check("rst_addr", 36'(sram_address), 36'(0));
      check("rst_be", 36'(sram_byteenable), 36'(0));
      check("rst_ready", 36'(px_ready), 36'(0));
      check("rst_busy", 36'(busy), 36'(0));
      check("rst_done", 36'(frame_done), 36'(0));
      check("rst_sync", 36'(sync_err), 36'(0));
      reset_reset = 1'b0;
      repeat (2) @(negedge clk_clk);
      check("idle_busy", 36'(busy), 36'(0));
      check("idle_ready", 36'(px_ready), 36'(0));

      // basic frame 0x1000..0x1007, buffer 0, start poked while busy
      stim_q.delete();
      for (int i = 0; i < FRAME; i++) stim_q.push_back({(i == 0) ? 1'b1 : 1'b0, 16'h1000 + 16'(i)});
      run_frame("basic", 1'b0, 1'b1, 1'b1, 1'b0);

      // buffer 1 with three junk pixels ahead of sop 0xABCD
      make_stream(3 + FRAME, 3, -1);
      stim_q[3] = {1'b1, 16'hABCD};
      gappy = 1'b1;
      run_frame("junk", 1'b1, 1'b0, 1'b0, 1'b0);
      gappy = 1'b0;
      check("junk_first_addr", 36'(wr_log.size() > 0 ? wr_log[0] : '0), {BUF1_BASE, 16'hABCD});

      // continuous valid: FIFO fills, px_ready drops, nothing lost
      make_stream(14, 0, -1);
      run_frame("backpressure", 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      check("backpressure_saw_full", 36'(saw_full), 36'(1));

      // sop on pixel 5 of 8 restarts the frame
      make_stream(5 + FRAME, 0, 5);
      gappy = 1'b1;
      run_frame("resync", 1'b0, 1'b0, 1'b0, 1'b0);
      gappy = 1'b0;

      // sop on the final pixel is a resync, not a completion
      make_stream(2 * FRAME - 1, 0, FRAME - 1);
      run_frame("last_sop", 1'b1, 1'b0, 1'b0, 1'b0);

      // asynchronous reset while a word is being written
      make_stream(1, 0, -1);
      @(negedge clk_clk);
      start = 1'b1;
      buf_sel = 1'b0;
      @(negedge clk_clk);
      start = 1'b0;
      drive_stream();
      n = 0;
      while (!sram_write && n < 60) begin
         @(negedge clk_clk);
         n++;
      end
      check("arst_reached_write", 36'(sram_write), 36'(1));
      reset_reset = 1'b1;
      #1;
      check("arst_write", 36'(sram_write), 36'(0));
      check("arst_cs", 36'(sram_chipselect), 36'(0));
      check("arst_be", 36'(sram_byteenable), 36'(0));
      check("arst_busy", 36'(busy), 36'(0));
      repeat (2) @(negedge clk_clk);
      reset_reset = 1'b0;
      @(negedge clk_clk);
      make_stream(FRAME, 0, -1);
      run_frame("after_reset", 1'b1, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
